// File: rtl/hdr_frame_counter.sv
// Frame counter: latches a command descriptor, derives its frame total, counts frame ticks down to done.
// Latency: start -> LOAD next cycle -> COUNT (frames valid) two cycles after start; tick -> outputs next cycle.
// Backpressure: i_fcnt_en low freezes the count; abort returns to IDLE and drops the command silently.
module hdr_frame_counter #(
    parameter int unsigned DATA_LEN_W      = 16,
    parameter int unsigned BYTES_PER_FRAME = 2,
    parameter int unsigned BITCNT_W        = 6,
    parameter int unsigned FRAME_LAST_BIT  = 19,
    parameter int unsigned CCC_OVH_BCAST   = 1,
    parameter int unsigned CCC_OVH_DIRECT  = 2,
    localparam int unsigned FRM_CNT_W      = DATA_LEN_W + 1
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fcnt_start,
    input  logic                  i_fcnt_en,
    input  logic                  i_fcnt_abort,
    input  logic                  i_regf_CMD_ATTR,
    input  logic [DATA_LEN_W-1:0] i_regf_DATA_LEN,
    input  logic [2:0]            i_regf_DTT,
    input  logic                  i_ccc_en,
    input  logic                  Direct_Broadcast_n,
    input  logic [BITCNT_W-1:0]   i_cnt_bit_count,
    input  logic                  i_scl_neg_edge,
    output logic                  o_fcnt_busy,
    output logic [FRM_CNT_W-1:0]  o_frames_left,
    output logic                  o_cccnt_last_frame,
    output logic                  o_frame_done,
    output logic                  o_cmd_done,
    output logic                  o_dtt_err
);

    // Ceil division by the frame width is a shift plus "any dropped bit set".
    localparam int unsigned SH = (BYTES_PER_FRAME == 4) ? 2 : ((BYTES_PER_FRAME == 2) ? 1 : 0);
    localparam logic [DATA_LEN_W-1:0] LEN_MASK = DATA_LEN_W'(BYTES_PER_FRAME - 1);
    localparam logic [2:0]            DTT_MASK = 3'(BYTES_PER_FRAME - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

    state_t                 state;
    logic                   attr_q;
    logic                   ccc_q;
    logic                   direct_q;
    logic [DATA_LEN_W-1:0]  len_q;
    logic [2:0]             dtt_q;

    logic                   dtt_over;
    logic [2:0]             dtt_clamp;
    logic [FRM_CNT_W-1:0]   pay_reg;
    logic [FRM_CNT_W-1:0]   pay_imm;
    logic [FRM_CNT_W-1:0]   ovh;
    logic [FRM_CNT_W-1:0]   total;
    logic                   tick;

    always_comb begin
        dtt_over  = (dtt_q > 3'd4);
        dtt_clamp = dtt_over ? 3'd4 : dtt_q;
        pay_reg   = FRM_CNT_W'(len_q >> SH) + FRM_CNT_W'(|(len_q & LEN_MASK));
        pay_imm   = FRM_CNT_W'(dtt_clamp >> SH) + FRM_CNT_W'(|(dtt_clamp & DTT_MASK));
        ovh       = '0;
        if (ccc_q) begin
            ovh = direct_q ? FRM_CNT_W'(CCC_OVH_DIRECT) : FRM_CNT_W'(CCC_OVH_BCAST);
        end
        total = (attr_q ? pay_imm : pay_reg) + ovh;
        tick  = i_fcnt_en & i_scl_neg_edge & (i_cnt_bit_count == BITCNT_W'(FRAME_LAST_BIT));
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= S_IDLE;
            attr_q             <= 1'b0;
            ccc_q              <= 1'b0;
            direct_q           <= 1'b0;
            len_q              <= '0;
            dtt_q              <= '0;
            o_fcnt_busy        <= 1'b0;
            o_frames_left      <= '0;
            o_cccnt_last_frame <= 1'b0;
            o_frame_done       <= 1'b0;
            o_cmd_done         <= 1'b0;
            o_dtt_err          <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            o_cmd_done   <= 1'b0;
            if (i_fcnt_abort) begin
                state              <= S_IDLE;
                o_fcnt_busy        <= 1'b0;
                o_frames_left      <= '0;
                o_cccnt_last_frame <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_fcnt_start) begin
                            attr_q      <= i_regf_CMD_ATTR;
                            len_q       <= i_regf_DATA_LEN;
                            dtt_q       <= i_regf_DTT;
                            ccc_q       <= i_ccc_en;
                            direct_q    <= Direct_Broadcast_n;
                            o_dtt_err   <= 1'b0;
                            o_fcnt_busy <= 1'b1;
                            state       <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        o_dtt_err <= attr_q & dtt_over;
                        if (total == '0) begin
                            state              <= S_DONE;
                            o_fcnt_busy        <= 1'b0;
                            o_cmd_done         <= 1'b1;
                            o_frames_left      <= '0;
                            o_cccnt_last_frame <= 1'b0;
                        end else begin
                            state              <= S_COUNT;
                            o_frames_left      <= total;
                            o_cccnt_last_frame <= (total == FRM_CNT_W'(1));
                        end
                    end
                    S_COUNT: begin
                        if (tick) begin
                            o_frame_done  <= 1'b1;
                            o_frames_left <= o_frames_left - FRM_CNT_W'(1);
                            if (o_frames_left == FRM_CNT_W'(1)) begin
                                state              <= S_DONE;
                                o_fcnt_busy        <= 1'b0;
                                o_cmd_done         <= 1'b1;
                                o_cccnt_last_frame <= 1'b0;
                            end else begin
                                o_cccnt_last_frame <= (o_frames_left == FRM_CNT_W'(2));
                            end
                        end
                    end
                    S_DONE: begin
                        state         <= S_IDLE;
                        o_frames_left <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdr_frame_counter.sv
// Bench for hdr_frame_counter: directed cases plus randomized commands checked against an arithmetic frame model.
// A second instance with one byte per frame covers the widest frame total.
module tb_hdr_frame_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        en = 1'b0;
    logic        abort = 1'b0;
    logic        attr = 1'b0;
    logic [15:0] len = '0;
    logic [2:0]  dtt = '0;
    logic        ccc = 1'b0;
    logic        dir = 1'b0;
    logic [5:0]  bitc = '0;
    logic        scl = 1'b0;

    logic        a_busy, a_last, a_fd, a_cd, a_err;
    logic [16:0] a_left;
    logic        b_busy, b_last, b_fd, b_cd, b_err;
    logic [16:0] b_left;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    hdr_frame_counter dut (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_fcnt_start(start), .i_fcnt_en(en),
        .i_fcnt_abort(abort), .i_regf_CMD_ATTR(attr), .i_regf_DATA_LEN(len),
        .i_regf_DTT(dtt), .i_ccc_en(ccc), .Direct_Broadcast_n(dir),
        .i_cnt_bit_count(bitc), .i_scl_neg_edge(scl),
        .o_fcnt_busy(a_busy), .o_frames_left(a_left), .o_cccnt_last_frame(a_last),
        .o_frame_done(a_fd), .o_cmd_done(a_cd), .o_dtt_err(a_err)
    );

    hdr_frame_counter #(.BYTES_PER_FRAME(1)) dut_bpf1 (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_fcnt_start(start), .i_fcnt_en(en),
        .i_fcnt_abort(abort), .i_regf_CMD_ATTR(attr), .i_regf_DATA_LEN(len),
        .i_regf_DTT(dtt), .i_ccc_en(ccc), .Direct_Broadcast_n(dir),
        .i_cnt_bit_count(bitc), .i_scl_neg_edge(scl),
        .o_fcnt_busy(b_busy), .o_frames_left(b_left), .o_cccnt_last_frame(b_last),
        .o_frame_done(b_fd), .o_cmd_done(b_cd), .o_dtt_err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Frames a command needs, straight from the descriptor rules.
    function automatic int ref_total(bit a, int l, int d, bit c, bit dr, int bpf);
        int p;
        int ov;
        if (a) p = (((d > 4) ? 4 : d) + bpf - 1) / bpf;
        else   p = (l + bpf - 1) / bpf;
        ov = c ? (dr ? 2 : 1) : 0;
        return p + ov;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 1'b0; abort = 1'b0; en = 1'b0; scl = 1'b0; bitc = '0;
    endtask

    task automatic noise(int n, bit pause, int left);
        for (int i = 0; i < n; i++) begin
            if (pause) begin
                en = 1'b0; scl = 1'b1; bitc = 6'd19;
            end else begin
                en   = 1'($urandom);
                scl  = 1'($urandom);
                bitc = ($urandom_range(0, 1) == 1) ? 6'd19 : 6'($urandom);
                if (en && scl && bitc == 6'd19) scl = 1'b0;
            end
            step();
            check("hold_frame_done", a_fd, 0);
            check("hold_frames_left", a_left, left);
            check("hold_last_frame", a_last, left == 1);
        end
        quiet();
    endtask

    task automatic run_cmd(bit a, int l, int d, bit c, bit dr, int pause_at, bit mid_start);
        int total;
        int left;
        total = ref_total(a, l, d, c, dr, 2);
        attr = a; len = 16'(l); dtt = 3'(d); ccc = c; dir = dr; start = 1'b1;
        step();
        start = 1'b0;
        attr = ~a; len = 16'($urandom); dtt = 3'($urandom); ccc = 1'($urandom); dir = 1'($urandom);
        check("load_busy", a_busy, 1);
        check("load_dtt_err_clear", a_err, 0);
        check("load_last", a_last, 0);
        step();
        check("dtt_err", a_err, a && d > 4);
        if (total == 0) begin
            check("zero_cmd_done", a_cd, 1);
            check("zero_busy", a_busy, 0);
            check("zero_last", a_last, 0);
            check("zero_frames", a_left, 0);
            step();
            check("zero_cmd_done_end", a_cd, 0);
            check("zero_idle_busy", a_busy, 0);
            return;
        end
        check("count_frames", a_left, total);
        check("count_busy", a_busy, 1);
        check("count_last", a_last, total == 1);
        check("count_cmd_done", a_cd, 0);
        left = total;
        for (int k = 1; k <= total; k++) begin
            noise($urandom_range(0, 3), 1'b0, left);
            if (pause_at == k) noise(10, 1'b1, left);
            if (mid_start && k == 2) begin
                start = 1'b1; attr = 1'b0; len = 16'd200;
                step();
                start = 1'b0;
                check("mid_start_frames", a_left, left);
                check("mid_start_busy", a_busy, 1);
            end
            en = 1'b1; scl = 1'b1; bitc = 6'd19;
            step();
            quiet();
            left--;
            check("tick_frame_done", a_fd, 1);
            check("tick_frames_left", a_left, left);
            check("tick_last", a_last, left == 1);
            check("tick_cmd_done", a_cd, left == 0);
            check("tick_busy", a_busy, left != 0);
        end
        step();
        check("end_frame_done", a_fd, 0);
        check("end_cmd_done", a_cd, 0);
        check("end_busy", a_busy, 0);
        check("end_frames", a_left, 0);
    endtask

    initial begin
        #3;
        check("rst_busy", a_busy, 0);
        check("rst_frames", a_left, 0);
        check("rst_last", a_last, 0);
        check("rst_frame_done", a_fd, 0);
        check("rst_cmd_done", a_cd, 0);
        check("rst_dtt_err", a_err, 0);
        check("rst_b_cmd_done", b_cd, 0);
        check("rst_b_dtt_err", b_err, 0);
        #9 rst_n = 1'b1;
        step();

        // Widest total: 0xFFFF bytes at one byte per frame plus broadcast overhead.
        attr = 1'b0; len = 16'hFFFF; ccc = 1'b1; dir = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("wide_busy", b_busy, 1);
        step();
        check("wide_frames_bpf1", b_left, 17'h10000);
        check("wide_frames_bpf2", a_left, ref_total(0, 65535, 0, 1, 0, 2));
        check("wide_last", b_last, 0);
        en = 1'b1; scl = 1'b1; bitc = 6'd19;
        step();
        quiet();
        check("wide_tick_frames", b_left, 17'h0FFFF);
        check("wide_tick_done", b_fd, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_frames", b_left, 0);
        check("arst_busy", b_busy, 0);
        check("arst_frame_done", b_fd, 0);
        check("arst_last", b_last, 0);
        check("arst_cmd_done", b_cd, 0);
        check("arst_a_frames", a_left, 0);
        check("arst_a_busy", a_busy, 0);
        #1 rst_n = 1'b1;
        step();
        check("arst_stays_idle", a_busy, 0);

        run_cmd(1'b0, 5, 0, 1'b0, 1'b0, -1, 1'b0);
        run_cmd(1'b1, 0, 3, 1'b1, 1'b0, -1, 1'b0);
        run_cmd(1'b1, 0, 6, 1'b0, 1'b0, -1, 1'b0);
        run_cmd(1'b0, 4, 0, 1'b1, 1'b1, 2, 1'b1);
        run_cmd(1'b0, 0, 0, 1'b0, 1'b0, -1, 1'b0);

        // Abort racing the last-frame tick.
        attr = 1'b0; len = 16'd4; ccc = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("abort_setup_frames", a_left, 2);
        en = 1'b1; scl = 1'b1; bitc = 6'd19;
        step();
        check("abort_pre_frames", a_left, 1);
        abort = 1'b1;
        step();
        quiet();
        check("abort_frames", a_left, 0);
        check("abort_last", a_last, 0);
        check("abort_frame_done", a_fd, 0);
        check("abort_cmd_done", a_cd, 0);
        check("abort_busy", a_busy, 0);
        step();
        check("abort_no_cmd_done", a_cd, 0);

        // Abort during LOAD.
        len = 16'd6; start = 1'b1;
        step();
        start = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_load_busy", a_busy, 0);
        step();
        check("abort_load_cmd_done", a_cd, 0);
        check("abort_load_frames", a_left, 0);

        // Start and abort together in IDLE: start is dropped.
        start = 1'b1; abort = 1'b1;
        step();
        quiet();
        check("start_abort_busy", a_busy, 0);
        step();
        check("start_abort_busy2", a_busy, 0);

        for (int i = 0; i < 25; i++) begin
            run_cmd(1'($urandom),
                    ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40)),
                    int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
